step_sequencer_param: RTL and testbench
=======================================

// Module: step_sequencer_param
// PURPOSE
//  Parametrised step sequencer: NUM_STEPS programmable steps, each with its own stored note and enable
//  bit, advanced at a runtime tempo (clk cycles per step). Supports forward, reverse and ping-pong
//  order, pause/resume and a gate output of programmable length. Sits between the key encoder and the
//  synth voice; drives note/gate to the voice and a one-hot step LED bar.
// PARAMETERS
//  NUM_STEPS  16  number of steps (>=1); SW = (NUM_STEPS>1) ? $clog2(NUM_STEPS) : 1
//  NOTE_W     4   note code width; note 0 = rest
//  TEMPO_W    23  width of period/gate_len counters
// PORTS
//  clk          in   1          system clock (10 kHz)
//  rst          in   1          asynchronous reset, active-high
//  seq_en       in   1          sequencer enable; 0 forces IDLE
//  play         in   1          level; 1 = run, 0 = pause
//  mode         in   2          00 fwd, 01 rev, 10 ping-pong, 11 = fwd
//  period       in   TEMPO_W    clk cycles per step; values <2 treated as 2
//  gate_len     in   TEMPO_W    gate high time in cycles; 0 = gate never asserted; >=period = legato
//  step_toggle  in   NUM_STEPS  one-cycle pulses; bit i inverts enable[i]
//  prog_we      in   1          write prog_note to note[prog_step], set enable[prog_step]=1
//  prog_step    in   SW         programming address (>=NUM_STEPS ignored)
//  prog_note    in   NOTE_W     programming data
//  note_out     out  NOTE_W     current note (registered)
//  gate         out  1          note gate (registered)
//  step_idx     out  SW         current step pointer
//  step_led     out  NUM_STEPS  one-hot of step_idx; all 0 in IDLE
//  beat_pulse   out  1          1-cycle pulse on every step trigger
// BEHAVIOUR
//  Reset: all outputs 0; note[] = 0, enable[] = 0, step 0, divider 0, direction up, state IDLE.
//  FSM: IDLE -> RUN when seq_en&&play; RUN -> PAUSE when play=0; PAUSE -> RUN when play=1;
//    any state -> IDLE when seq_en=0 (step, divider, direction cleared; note_out/gate 0 next edge).
//  Trigger on IDLE->RUN edge: step 0 triggered immediately (beat_pulse=1 that edge), divider=0.
//  RUN: divider increments each cycle; when div >= period_eff-1 -> div=0, step advances, trigger.
//    Use >= so period reduced mid-step never stalls. period changes take effect immediately.
//  Trigger of step s (same edge step_idx<=s): note_out <= enable[s] ? note[s] : 0;
//    gate <= enable[s] && note[s]!=0 && gate_len!=0; gate counter loaded with gate_len.
//  Gate drops after exactly gate_len cycles high; if gate_len >= period_eff gate stays high into the
//    next trigger (legato, no low cycle between enabled steps). note_out holds until next trigger.
//  Order: fwd wraps N-1->0; rev wraps 0->N-1; ping-pong 0..N-1..0, endpoints not repeated; N=1 stays 0.
//    Mode change takes effect at the next advance; entering ping-pong uses stored direction.
//  PAUSE: divider, gate counter, step held; note_out=0, gate=0 while paused; resume does not
//    retrigger the current step; beat_pulse 0.
//  Programming: allowed in any state; affects a step from its next trigger. prog_we and
//    step_toggle to the same step in the same cycle: prog_we wins. Out-of-range prog_step ignored.
//  No combinational input->output paths; all outputs registered.
// STRUCTURE
//  Package seq_pkg: seq_mode_t enum (FWD, REV, PING), seq_state_t enum (IDLE, RUN, PAUSE), MIN_PERIOD=2.
//  Sub-module seq_step_gen: divider + step pointer + direction (inputs run/mode/period, outputs
//    step, trigger). Top holds note/enable storage, FSM, gate counter, LED decode.
// TESTING
//  1 N=8, period=4, fwd, all steps enabled notes 1..8, gate_len=2 -> beat_pulse every 4 clk,
//    note_out 1,2..8,1; gate 2 high / 2 low per step.
//  2 Ping-pong, N=4 -> step_idx 0,1,2,3,2,1,0,1; rev -> 0,3,2,1,0.
//  3 Drop play for 10 cycles mid-step 3 -> note_out/gate 0, step_idx=3 held; on resume step 4 after
//    remaining divider count, no retrigger of step 3.
//  4 step_toggle on step 2 (disable), gate_len=period=4 -> step 2 note_out 0, gate 0; other steps
//    gate continuously high (legato).
//  5 Assert rst mid-gate, and separately drop seq_en -> all outputs 0 asynchronously / next edge;
//    next seq_en&&play triggers step 0 on the first edge.
//  6 prog_we and step_toggle same step same cycle; period shrunk 20->3 with div=10 -> enable=1,
//    note written; advance next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer.
package seq_pkg;
  typedef enum logic [1:0] {FWD = 2'b00, REV = 2'b01, PING = 2'b10} seq_mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} seq_state_t;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/step_sequencer_param_if.sv
// Control/programming inputs and note/gate/LED outputs of the step sequencer.
interface step_sequencer_param_if #(
  parameter int NUM_STEPS = 16,
  parameter int NOTE_W    = 4,
  parameter int TEMPO_W   = 23
);
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                     seq_en;
  logic                     play;
  logic [1:0]               mode;
  logic [TEMPO_W-1:0]       period;
  logic [TEMPO_W-1:0]       gate_len;
  logic [NUM_STEPS-1:0]     step_toggle;
  logic                     prog_we;
  logic [SW-1:0]            prog_step;
  logic [NOTE_W-1:0]        prog_note;
  logic [NOTE_W-1:0]        note_out;
  logic                     gate;
  logic [SW-1:0]            step_idx;
  logic [NUM_STEPS-1:0]     step_led;
  logic                     beat_pulse;
  seq_pkg::seq_state_t      state;

  modport master (
    output seq_en, play, mode, period, gate_len, step_toggle, prog_we, prog_step, prog_note,
    input  note_out, gate, step_idx, step_led, beat_pulse, state
  );
  modport slave (
    input  seq_en, play, mode, period, gate_len, step_toggle, prog_we, prog_step, prog_note,
    output note_out, gate, step_idx, step_led, beat_pulse, state
  );
endinterface

// File: rtl/seq_step_gen.sv
// Tempo divider, step pointer and ping-pong direction; flags the edge on which a step triggers.
module seq_step_gen
  import seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int TEMPO_W   = 23,
  parameter int SW        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               start,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [TEMPO_W-1:0] period,
  output logic               trigger,
  output logic [SW-1:0]      step,
  output logic [SW-1:0]      step_nxt
);
  localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

  logic [TEMPO_W-1:0] div;
  logic [TEMPO_W-1:0] period_eff;
  logic               dir_down;
  logic               dir_down_nxt;
  logic [SW-1:0]      adv_step;
  logic               wrap;

  assign period_eff = (period < TEMPO_W'(MIN_PERIOD)) ? TEMPO_W'(MIN_PERIOD) : period;
  // >= rather than == so shrinking the period mid-step advances at once instead of stalling.
  assign wrap       = run && (div >= period_eff - TEMPO_W'(1));
  assign trigger    = start || wrap;

  always_comb begin
    adv_step     = step;
    dir_down_nxt = dir_down;
    if (NUM_STEPS > 1) begin
      case (mode)
        REV:     adv_step = (step == '0) ? LAST : step - SW'(1);
        PING: begin
          if (!dir_down) begin
            if (step == LAST) begin
              adv_step     = step - SW'(1);
              dir_down_nxt = 1'b1;
            end else begin
              adv_step = step + SW'(1);
            end
          end else begin
            if (step == '0) begin
              adv_step     = SW'(1);
              dir_down_nxt = 1'b0;
            end else begin
              adv_step = step - SW'(1);
            end
          end
        end
        default: adv_step = (step == LAST) ? '0 : step + SW'(1);
      endcase
    end
  end

  assign step_nxt = (clear || start) ? '0 : (wrap ? adv_step : step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      step     <= '0;
      dir_down <= 1'b0;
    end else if (clear || start) begin
      div      <= '0;
      step     <= '0;
      dir_down <= 1'b0;
    end else if (wrap) begin
      div      <= '0;
      step     <= adv_step;
      dir_down <= dir_down_nxt;
    end else if (run) begin
      div <= div + TEMPO_W'(1);
    end
  end
endmodule

// File: rtl/step_sequencer_param.sv
// Step sequencer top: note/enable storage, run/pause FSM, gate timer and step LED decode.
module step_sequencer_param
  import seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int NOTE_W    = 4,
  parameter int TEMPO_W   = 23
) (
  input logic                  clk,
  input logic                  rst,
  step_sequencer_param_if.slave bus
);
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  seq_state_t          state, state_nxt;
  logic [NOTE_W-1:0]   notes [NUM_STEPS];
  logic [NUM_STEPS-1:0] enable, en_nxt;
  logic [NOTE_W-1:0]   cur_note;
  logic [TEMPO_W-1:0]  gate_cnt, gate_dec;
  logic                start, run, clear, trigger, prog_ok;
  logic [SW-1:0]       step, step_nxt;
  logic                trig_en, trig_gate;
  logic [NOTE_W-1:0]   trig_note;

  assign clear = !bus.seq_en;
  assign start = (state == IDLE) && bus.seq_en && bus.play;
  // PAUSE->RUN counts like a normal running cycle, so paused cycles simply stretch the step.
  assign run   = (state != IDLE) && bus.seq_en && bus.play;

  always_comb begin
    state_nxt = state;
    if (!bus.seq_en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.play) state_nxt = RUN;
        RUN:     if (!bus.play) state_nxt = PAUSE;
        PAUSE:   if (bus.play) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  seq_step_gen #(.NUM_STEPS(NUM_STEPS), .TEMPO_W(TEMPO_W), .SW(SW)) u_step_gen (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .run(run),
    .mode(bus.mode), .period(bus.period),
    .trigger(trigger), .step(step), .step_nxt(step_nxt)
  );

  assign prog_ok = bus.prog_we && ({1'b0, bus.prog_step} < (SW + 1)'(NUM_STEPS));

  // Toggles first, then the write, so a write to the same step always leaves it enabled.
  always_comb begin
    en_nxt = enable ^ bus.step_toggle;
    if (prog_ok) en_nxt[bus.prog_step] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) notes[i] <= '0;
      enable <= '0;
    end else begin
      enable <= en_nxt;
      if (prog_ok) notes[bus.prog_step] <= bus.prog_note;
    end
  end

  assign trig_en   = enable[step_nxt];
  assign trig_note = trig_en ? notes[step_nxt] : '0;
  assign trig_gate = trig_en && (notes[step_nxt] != '0) && (bus.gate_len != '0);
  assign gate_dec  = (gate_cnt != '0) ? gate_cnt - TEMPO_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.note_out   <= '0;
      bus.gate       <= 1'b0;
      bus.beat_pulse <= 1'b0;
      bus.step_led   <= '0;
      cur_note       <= '0;
      gate_cnt       <= '0;
    end else begin
      bus.beat_pulse <= trigger;
      bus.step_led   <= (state_nxt == IDLE) ? '0 : (NUM_STEPS'(1) << step_nxt);
      if (trigger) begin
        cur_note     <= trig_note;
        bus.note_out <= trig_note;
        bus.gate     <= trig_gate;
        gate_cnt     <= trig_gate ? bus.gate_len : '0;
      end else if (run) begin
        bus.note_out <= cur_note;
        bus.gate     <= (gate_dec != '0);
        gate_cnt     <= gate_dec;
      end else begin
        bus.note_out <= '0;
        bus.gate     <= 1'b0;
        if (state_nxt == IDLE) begin
          cur_note <= '0;
          gate_cnt <= '0;
        end
      end
    end
  end

  assign bus.step_idx = step;
  assign bus.state    = state;
endmodule

// File: tb/tb_step_sequencer_param.sv
// Bench for step_sequencer_param: directed scenarios plus randomized traffic against a behavioural model.
module tb_step_sequencer_param;
  import seq_pkg::*;

  localparam int N  = 8;
  localparam int NW = 4;
  localparam int TW = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;

  step_sequencer_param_if #(.NUM_STEPS(N), .NOTE_W(NW), .TEMPO_W(TW)) bus ();

  step_sequencer_param #(.NUM_STEPS(N), .NOTE_W(NW), .TEMPO_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Reference model: states 0 idle, 1 run, 2 pause; gate judged by age since trigger.
  int m_st, m_step, m_div, m_dir, m_age, m_gl, m_cur;
  bit m_gon;
  int m_note_o, m_gate_o, m_beat, m_led;
  int m_notes[N];
  bit m_en[N];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_step = 0; m_div = 0; m_dir = 1; m_age = 0; m_gl = 0; m_cur = 0; m_gon = 0;
    m_note_o = 0; m_gate_o = 0; m_beat = 0; m_led = 0;
    for (int i = 0; i < N; i++) begin m_notes[i] = 0; m_en[i] = 0; end
  endtask

  task automatic model_trigger();
    m_beat   = 1;
    m_cur    = m_en[m_step] ? m_notes[m_step] : 0;
    m_gon    = m_en[m_step] && (m_notes[m_step] != 0) && (bus.gate_len != 0);
    m_gl     = int'(bus.gate_len);
    m_age    = 0;
    m_note_o = m_cur;
    m_gate_o = m_gon;
  endtask

  task automatic model_edge();
    int pe;
    pe = (bus.period < 2) ? 2 : int'(bus.period);
    m_beat = 0;
    if (!bus.seq_en) begin
      m_st = 0; m_step = 0; m_div = 0; m_dir = 1; m_age = 0; m_gon = 0; m_cur = 0;
      m_note_o = 0; m_gate_o = 0;
    end else if (m_st == 0) begin
      if (bus.play) begin
        m_st = 1; m_step = 0; m_div = 0; m_dir = 1;
        model_trigger();
      end else begin
        m_note_o = 0; m_gate_o = 0;
      end
    end else if (bus.play) begin
      m_st = 1;
      if (m_div >= pe - 1) begin
        m_div = 0;
        case (bus.mode)
          2'b01: m_step = (m_step + N - 1) % N;
          2'b10: if (N > 1) begin
            if (m_step + m_dir < 0 || m_step + m_dir > N - 1) m_dir = -m_dir;
            m_step = m_step + m_dir;
          end
          default: m_step = (m_step + 1) % N;
        endcase
        model_trigger();
      end else begin
        m_div++;
        m_age++;
        m_note_o = m_cur;
        m_gate_o = m_gon && (m_age < m_gl);
      end
    end else begin
      m_st = 2; m_note_o = 0; m_gate_o = 0;
    end
    m_led = (m_st == 0) ? 0 : (1 << m_step);
    for (int i = 0; i < N; i++) if (bus.step_toggle[i]) m_en[i] = !m_en[i];
    if (bus.prog_we && int'(bus.prog_step) < N) begin
      m_notes[bus.prog_step] = int'(bus.prog_note);
      m_en[bus.prog_step]    = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("note_out", 32'(bus.note_out), m_note_o);
    check("gate", 32'(bus.gate), m_gate_o);
    check("step_idx", 32'(bus.step_idx), m_step);
    check("step_led", 32'(bus.step_led), m_led);
    check("beat", 32'(bus.beat_pulse), m_beat);
    check("state", 32'(bus.state), m_st);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic prog(int s, int n);
    bus.prog_we = 1'b1; bus.prog_step = 3'(s); bus.prog_note = 4'(n);
    cycle();
    bus.prog_we = 1'b0;
  endtask

  task automatic restart();
    bus.seq_en = 1'b0;
    cycle();
    bus.seq_en = 1'b1;
  endtask

  // On every beat pop exp_q and compare against note_out (use_note) or step_idx.
  task automatic beats_check(string tag, int max_cycles, bit use_note);
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
      cycle();
      if (bus.beat_pulse) begin
        if (use_note) check(tag, 32'(bus.note_out), exp_q.pop_front());
        else          check(tag, 32'(bus.step_idx), exp_q.pop_front());
      end
    end
    check({tag, "_done"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int last, gap, viol, found;
    bus.seq_en = 0; bus.play = 0; bus.mode = 0; bus.period = 4; bus.gate_len = 2;
    bus.step_toggle = '0; bus.prog_we = 0; bus.prog_step = '0; bus.prog_note = '0;
    model_reset();
    repeat (2) cycle();
    check("rst_note", 32'(bus.note_out), 0);
    check("rst_led", 32'(bus.step_led), 0);
    check("rst_state", 32'(bus.state), 0);
    rst = 1'b0;

    // Scenario 1: forward, period 4, gate 2.
    for (int i = 0; i < N; i++) prog(i, i + 1);
    bus.seq_en = 1; bus.play = 1;
    for (int i = 1; i <= N; i++) exp_q.push_back(i);
    exp_q.push_back(1);
    last = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      cycle();
      if (bus.beat_pulse) begin
        check("t1_note", 32'(bus.note_out), exp_q.pop_front());
        if (c > 0) check("t1_gap", c - last, 4);
        last = c;
      end
    end
    check("t1_done", exp_q.size(), 0);
    exp_q.delete();

    // Scenario 2: ping-pong then reverse step order.
    bus.mode = 2'b10; restart();
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    for (int i = N - 2; i >= 0; i--) exp_q.push_back(i);
    exp_q.push_back(1);
    beats_check("t2_ping", 80, 1'b0);
    bus.mode = 2'b01; restart();
    exp_q.push_back(0);
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(i);
    beats_check("t2_rev", 50, 1'b0);

    // Scenario 3: pause one cycle into step 3.
    bus.mode = 2'b00; restart();
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (bus.beat_pulse && bus.step_idx == 3) found = 1;
    end
    check("t3_reach", found, 1);
    cycle();
    bus.play = 0;
    repeat (10) begin
      cycle();
      check("t3_pause_note", 32'(bus.note_out), 0);
      check("t3_pause_step", 32'(bus.step_idx), 3);
    end
    bus.play = 1;
    gap = 0; found = 0;
    for (int c = 1; c <= 10 && !found; c++) begin
      cycle();
      if (bus.beat_pulse) begin gap = c; found = 1; end
    end
    check("t3_resume_gap", gap, 3);
    check("t3_resume_step", 32'(bus.step_idx), 4);

    // Scenario 4: step 2 disabled, legato gate elsewhere.
    bus.gate_len = 4;
    bus.step_toggle = N'(1) << 2;
    cycle();
    bus.step_toggle = '0;
    restart();
    viol = 0;
    repeat (36) begin
      cycle();
      if (bus.step_idx == 2) viol += (bus.note_out != 0 || bus.gate != 0) ? 1 : 0;
      else viol += (bus.gate != 1) ? 1 : 0;
    end
    check("t4_legato", viol, 0);
    bus.step_toggle = N'(1) << 2;
    cycle();
    bus.step_toggle = '0;

    // Scenario 5: async reset mid-gate, then seq_en drop.
    bus.gate_len = 3;
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_note", 32'(bus.note_out), 0);
    check("t5_rst_gate", 32'(bus.gate), 0);
    check("t5_rst_led", 32'(bus.step_led), 0);
    check("t5_rst_step", 32'(bus.step_idx), 0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("t5_rst_restart", 32'(bus.beat_pulse), 1);
    for (int i = 0; i < N; i++) prog(i, i + 1);
    bus.seq_en = 0;
    cycle();
    check("t5_off_note", 32'(bus.note_out), 0);
    check("t5_off_state", 32'(bus.state), 0);
    bus.seq_en = 1;
    cycle();
    check("t5_on_beat", 32'(bus.beat_pulse), 1);
    check("t5_on_note", 32'(bus.note_out), 1);

    // Scenario 6: write+toggle same step, period shrink 20->3 at div 10.
    bus.period = 20; bus.gate_len = 5;
    bus.step_toggle = N'(1) << 6;
    cycle();
    bus.step_toggle = '0;
    restart();
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      cycle();
      if (m_div == 10) found = 1;
    end
    check("t6_reach_div", found, 1);
    bus.period = 3; bus.prog_we = 1; bus.prog_step = 3'd6; bus.prog_note = 4'd9;
    bus.step_toggle = N'(1) << 6;
    cycle();
    bus.prog_we = 0; bus.step_toggle = '0;
    check("t6_adv", 32'(bus.beat_pulse), 1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (bus.beat_pulse && bus.step_idx == 6) begin
        check("t6_note", 32'(bus.note_out), 9);
        found = 1;
      end
    end
    check("t6_found", found, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.seq_en = ($urandom_range(0, 99) < 98);
      if ($urandom_range(0, 99) < 4) bus.play = ~bus.play;
      if ($urandom_range(0, 99) < 2) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) bus.period = TW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) bus.gate_len = TW'($urandom_range(0, 9));
      bus.step_toggle = ($urandom_range(0, 99) < 5) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      bus.prog_we   = ($urandom_range(0, 99) < 5);
      bus.prog_step = 3'($urandom_range(0, N - 1));
      bus.prog_note = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
